dram_arbiter: RTL and testbench

Two-requester arbiter for the single-port, synchronous-read data RAM (1-cycle read latency).
- Port 0 is the MEM stage (load/store). Port 1 is a secondary read-only requester (instruction-fetch refill / display read).
- Grants one access per cycle, routes read data back to the owning requester one cycle later, and prevents port 1 starvation with a bounded counter.

---
 rtl/dram_arbiter.sv | 141 ++++++++++++++
 tb/tb_dram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-requester arbiter in front of a single-port data RAM with a
// 1-cycle synchronous read. Port 0 (MEM stage) has priority. Port 1 (read-only
// refill/display) is protected from starvation by a saturating wait counter.
// Read data is steered back to whichever port owned the read one cycle earlier.
module dram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_wen,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Counter is 4 bits wide, so legal limits are 1..15.
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    owner_e      rd_owner_r;
    owner_e      rd_owner_nxt_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_nxt_s;
    logic        m0_gnt_s;
    logic        m1_gnt_s;

    // Grant decision: port 0 wins ties unless port 1 has waited out the limit;
    // nothing is granted while reset is asserted.
    always_comb begin
        m0_gnt_s = 1'b0;
        m1_gnt_s = 1'b0;
        if (!resetn) begin
            m0_gnt_s = 1'b0;
            m1_gnt_s = 1'b0;
        end else begin
            case ({m0_req, m1_req})
                2'b11: begin
                    if (starve_cnt_r == LIMIT) begin
                        m1_gnt_s = 1'b1;
                    end else begin
                        m0_gnt_s = 1'b1;
                    end
                end
                2'b10:   m0_gnt_s = 1'b1;
                2'b01:   m1_gnt_s = 1'b1;
                default: begin
                    m0_gnt_s = 1'b0;
                    m1_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // RAM request mux: address/data follow the granted port; port 1 never writes.
    always_comb begin
        ram_en    = m0_gnt_s | m1_gnt_s;
        ram_wen   = m0_wen & {4{m0_gnt_s}};
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = 32'd0;
        if (m0_gnt_s) begin
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt_s) begin
            ram_addr  = m1_addr;
            ram_wdata = 32'd0;
        end else begin
            ram_addr  = {ADDR_W{1'b0}};
            ram_wdata = 32'd0;
        end
    end

    // Next read owner: remembers which port issued the read now in flight.
    always_comb begin
        rd_owner_nxt_s = OWN_NONE;
        if (m0_gnt_s && (m0_wen == 4'd0)) begin
            rd_owner_nxt_s = OWN_M0;
        end else if (m1_gnt_s) begin
            rd_owner_nxt_s = OWN_M1;
        end else begin
            rd_owner_nxt_s = OWN_NONE;
        end
    end

    // Next starvation count: clears once port 1 is served or stops asking,
    // counts port-0 grants that made port 1 wait, saturating at the limit.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (m1_gnt_s || !m1_req) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (m0_gnt_s) begin
            if (starve_cnt_r >= LIMIT) begin
                starve_cnt_nxt_s = LIMIT;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State registers; reset drops any outstanding read immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_owner_r   <= OWN_NONE;
            starve_cnt_r <= 4'd0;
        end else begin
            rd_owner_r   <= rd_owner_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Output decode: grants and read-return steering.
    always_comb begin
        m0_gnt    = m0_gnt_s;
        m1_gnt    = m1_gnt_s;
        m0_rvalid = (rd_owner_r == OWN_M0);
        m1_rvalid = (rd_owner_r == OWN_M1);
        m0_rdata  = m0_rvalid ? ram_rdata : 32'd0;
        m1_rdata  = m1_rvalid ? ram_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_dram_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [3:0]  m0_wen;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    dram_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: 64 words, synchronous read, byte-write.
    logic [31:0] ram_mem [64];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen == 4'd0) begin
                ram_rdata <= ram_mem[ram_addr[7:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          exp_owner;      // 0 none, 1 port0, 2 port1
    logic [31:0] exp_data;
    int          starve;         // port-0 grants port 1 has waited through
    logic        eg0, eg1;       // expected grants this cycle
    int          n_checks = 0;
    int          n_errs   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;   // 0x10
            8:       return 32'h12345678;   // 0x20
            16:      return 32'h11112222;   // 0x40
            17:      return 32'h33334444;   // 0x44
            default: return 32'hA5A50000 ^ (32'(i) * 32'h01030507);
        endcase
    endfunction

    // Check all outputs against the model, shortly after inputs settle.
    task automatic settle();
        #1;
        if (!resetn) begin
            exp_owner = 0;
            starve    = 0;
            eg0 = 1'b0; eg1 = 1'b0;
        end else if (m0_req && m1_req) begin
            eg1 = (starve == LIMIT);
            eg0 = !eg1;
        end else begin
            eg0 = m0_req;
            eg1 = m1_req;
        end
        check_eq("m0_gnt", m0_gnt, eg0);
        check_eq("m1_gnt", m1_gnt, eg1);
        check_eq("ram_en", ram_en, eg0 | eg1);
        check_eq("ram_wen", ram_wen, eg0 ? m0_wen : 4'd0);
        if (eg0) begin
            check_eq("ram_addr0", ram_addr, m0_addr);
            check_eq("ram_wdata", ram_wdata, m0_wdata);
        end else if (eg1) begin
            check_eq("ram_addr1", ram_addr, m1_addr);
        end
        check_eq("m0_rvalid", m0_rvalid, exp_owner == 1);
        check_eq("m1_rvalid", m1_rvalid, exp_owner == 2);
        check_eq("m0_rdata", m0_rdata, (exp_owner == 1) ? exp_data : 32'd0);
        check_eq("m1_rdata", m1_rdata, (exp_owner == 2) ? exp_data : 32'd0);
    endtask

    // Advance one clock and update the model from this cycle's transaction.
    task automatic advance();
        @(posedge clk);
        if (resetn) begin
            if (eg0 && m0_wen == 4'd0) begin
                exp_owner = 1; exp_data = ref_mem[m0_addr[7:2]];
            end else if (eg1) begin
                exp_owner = 2; exp_data = ref_mem[m1_addr[7:2]];
            end else begin
                exp_owner = 0;
            end
            if (eg0 && m0_wen != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (m0_wen[b]) ref_mem[m0_addr[7:2]][8*b +: 8] = m0_wdata[8*b +: 8];
            end
            if (eg1 || !m1_req) starve = 0;
            else if (eg0 && starve < LIMIT) starve++;
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic [3:0] w0,
                         input logic [31:0] d0, input logic r1, input logic [31:0] a1);
        @(negedge clk);
        m0_req = r0; m0_addr = a0; m0_wen = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1;
    endtask

    initial begin
        resetn = 1'b1;
        m0_req = 1'b0; m0_addr = 32'd0; m0_wen = 4'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_addr = 32'd0;
        exp_owner = 0; exp_data = 32'd0; starve = 0; eg0 = 1'b0; eg1 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] <= init_word(i);
            ref_mem[i] =  init_word(i);
        end
        #2 resetn = 1'b0;
        repeat (2) begin @(negedge clk); settle(); advance(); end

        // 1: reset release idle, then port-0 read
        @(negedge clk); resetn = 1'b1; settle();
        check_eq("t1_idle_en", ram_en, 1'b0);
        advance();
        drive(1'b1, 32'h10, 4'd0, 32'd0, 1'b0, 32'd0); settle();
        check_eq("t1_gnt", m0_gnt, 1'b1); advance();
        drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0); settle();
        check_eq("t1_rvalid", m0_rvalid, 1'b1);
        check_eq("t1_rdata", m0_rdata, 32'hDEADBEEF);
        check_eq("t1_m1_rvalid", m1_rvalid, 1'b0);
        advance();

        // 2: byte write then read-back
        drive(1'b1, 32'h20, 4'b0100, 32'h00AB0000, 1'b0, 32'd0); settle();
        check_eq("t2_wen", ram_wen, 4'b0100);
        check_eq("t2_wdata", ram_wdata, 32'h00AB0000);
        advance();
        drive(1'b1, 32'h20, 4'd0, 32'd0, 1'b0, 32'd0); settle();
        check_eq("t2_no_rvalid", m0_rvalid, 1'b0); advance();
        drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0); settle();
        check_eq("t2_byte2", m0_rdata[23:16], 8'hAB);
        check_eq("t2_word", m0_rdata, 32'h12AB5678);
        advance();

        // 3: port-1 read then port-0 read back-to-back
        drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h40); settle();
        check_eq("t3_m1_gnt", m1_gnt, 1'b1); advance();
        drive(1'b1, 32'h44, 4'd0, 32'd0, 1'b0, 32'd0); settle();
        check_eq("t3_m1_rvalid", m1_rvalid, 1'b1);
        check_eq("t3_m0_gnt", m0_gnt, 1'b1);
        check_eq("t3_m1_rdata", m1_rdata, 32'h11112222);
        advance();
        drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0); settle();
        check_eq("t3_m0_rdata", m0_rdata, 32'h33334444);
        check_eq("t3_m1_quiet", m1_rvalid, 1'b0);
        advance();

        // 4: both requesting continuously
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 4'd0, 32'd0, 1'b1, 32'(64 + i * 4)); settle();
            check_eq("t4_m1_gnt", m1_gnt, (i == 4) || (i == 9)); advance();
        end

        // 5: port 1 drops after two starved cycles, then returns
        drive(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0); settle(); advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h8, 4'd0, 32'd0, 1'b1, 32'h48); settle();
            check_eq("t5_starved", m1_gnt, 1'b0); advance();
        end
        drive(1'b1, 32'h8, 4'd0, 32'd0, 1'b0, 32'h48); settle(); advance();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h8, 4'd0, 32'd0, 1'b1, 32'h48); settle();
            check_eq("t5_m1_gnt", m1_gnt, i == 4); advance();
        end

        // 6: reset asserted the cycle after a port-0 read grant
        drive(1'b1, 32'h10, 4'd0, 32'd0, 1'b0, 32'd0); settle(); advance();
        @(negedge clk); resetn = 1'b0; m1_req = 1'b1; settle();
        check_eq("t6_rvalid_rst", m0_rvalid, 1'b0);
        check_eq("t6_gnt_rst", m0_gnt | m1_gnt | ram_en, 1'b0);
        check_eq("t6_wen_rst", ram_wen, 4'd0);
        advance();
        @(negedge clk); resetn = 1'b1; m0_req = 1'b0; m1_req = 1'b0; settle();
        check_eq("t6_stale", m0_rvalid | m1_rvalid, 1'b0); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h4, 4'd0, 32'd0, 1'b1, 32'h4C); settle();
            check_eq("t6_cnt_clear", m1_gnt, i == 4); advance();
        end

        // Random traffic with request hold-until-grant and rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 249) != 0);
            if (!m0_req || eg0) begin
                m0_req   = ($urandom_range(0, 3) != 0);
                m0_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                m0_wen   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
                m0_wdata = $urandom;
            end
            if (!m1_req || eg1) begin
                m1_req  = ($urandom_range(0, 2) != 0);
                m1_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            end
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
